count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor_pkg.sv | 14 +
 rtl/count_step_check.sv | 22 ++
 rtl/count_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count monitor.
package count_monitor_pkg;

    // Monitor FSM encoding, visible on the state output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } state_t;

    // Default width of the monitored count and all count registers.
    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/count_step_check.sv
// Combinational checks of one sample against the previous one and the limit.
module count_step_check #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] limit,
    output logic             step_bad,
    output logic             limit_bad
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Addition truncates to WIDTH bits, so all-ones -> 0 is a legal step.
    logic [WIDTH-1:0] expected;

    assign expected  = prev + STEP_W;
    assign step_bad  = (cnt_in != expected);
    assign limit_bad = (cnt_in > limit);

endmodule

// File: rtl/count_monitor.sv
// Monitors an upstream counter: checks the step between valid samples and an
// upper limit, latches the first failure and holds it until acknowledged.
//
// Sample semantics: cnt_in is consumed on every rising edge where cnt_valid is
// high and the FSM is in IDLE or TRACK; there is no back-pressure, and samples
// presented while in FAIL are dropped.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic [WIDTH-1:0] limit,
    input  logic             restart,
    input  logic             clr_err,
    output logic [1:0]       state,
    output logic             err_step,
    output logic             err_limit,
    output logic             fail_pulse,
    output logic [WIDTH-1:0] fail_value,
    output logic [WIDTH-1:0] fail_index,
    output logic [WIDTH-1:0] sample_cnt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           cur;
    logic [WIDTH-1:0] prev;
    logic             step_bad;
    logic             limit_bad;

    assign state = cur;

    count_step_check #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_check (
        .prev      (prev),
        .cnt_in    (cnt_in),
        .limit     (limit),
        .step_bad  (step_bad),
        .limit_bad (limit_bad)
    );

    // FSM with registered flags, capture registers and sample counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur        <= IDLE;
            prev       <= '0;
            err_step   <= 1'b0;
            err_limit  <= 1'b0;
            fail_pulse <= 1'b0;
            fail_value <= '0;
            fail_index <= '0;
            sample_cnt <= '0;
        end else if (restart) begin
            cur        <= IDLE;
            prev       <= '0;
            err_step   <= 1'b0;
            err_limit  <= 1'b0;
            fail_pulse <= 1'b0;
            fail_value <= '0;
            fail_index <= '0;
            sample_cnt <= '0;
        end else begin
            fail_pulse <= 1'b0;
            case (cur)
                IDLE: begin
                    // First sample only seeds the reference value.
                    if (cnt_valid) begin
                        prev       <= cnt_in;
                        sample_cnt <= ONE;
                        cur        <= TRACK;
                    end
                end
                TRACK: begin
                    if (cnt_valid) begin
                        if (step_bad || limit_bad) begin
                            cur        <= FAIL;
                            fail_pulse <= 1'b1;
                            err_step   <= step_bad;
                            err_limit  <= limit_bad;
                            fail_value <= cnt_in;
                            fail_index <= sample_cnt;
                        end else begin
                            prev <= cnt_in;
                            if (sample_cnt != '1) begin
                                sample_cnt <= sample_cnt + ONE;
                            end
                        end
                    end
                end
                FAIL: begin
                    // Everything is frozen until the failure is acknowledged.
                    if (clr_err) begin
                        cur        <= IDLE;
                        err_step   <= 1'b0;
                        err_limit  <= 1'b0;
                        fail_value <= '0;
                        fail_index <= '0;
                        sample_cnt <= '0;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule
